// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller
// Time-multiplexed driver for an eight-digit common-anode seven-segment display.
// A prescaler divides clk into digit slots; each slot selects one digit from a
// shadow copy of the inputs. The shadow only updates at a frame boundary.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros on
// digits 7..1. Digit 0 is never blanked.
module seven_seg_scan_controller #(
   parameter int unsigned CLK_DIV = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] digits_in,
   input  logic [7:0]  digit_en,
   input  logic [7:0]  dp_in,
   input  logic        load,
   output logic        load_ack,
   output logic [3:0]  BCD,
   output logic [7:0]  anode,
   output logic        dp_n,
   output logic        frame_start
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] PRESC_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] presc_r;
   logic [2:0]    idx_r;
   logic [31:0]   shadow_digits_r;
   logic [7:0]    shadow_en_r;
   logic [7:0]    shadow_dp_r;
   logic [7:0]    anode_r;
   logic [3:0]    bcd_r;
   logic          dp_n_r;
   logic          frame_start_r;

   logic          tick_s;
   logic          boundary_s;
   logic          capture_s;
   logic [2:0]    nxt_idx_s;
   logic [31:0]   nxt_digits_s;
   logic [7:0]    nxt_en_s;
   logic [7:0]    nxt_dp_s;
   logic [7:0]    lz_blank_s;
   logic [3:0]    sel_nib_s;
   logic [7:0]    anode_nxt_s;
   logic [3:0]    bcd_nxt_s;
   logic          dp_n_nxt_s;

   // Slot timing, frame boundary detection, and the shadow contents that the
   // next output update will see (new inputs when capturing this edge).
   always_comb begin
      tick_s     = (presc_r == PRESC_LAST);
      boundary_s = tick_s && (idx_r == 3'd7);
      capture_s  = boundary_s && load;
      nxt_idx_s  = idx_r + 3'd1;
      if (capture_s) begin
         nxt_digits_s = digits_in;
         nxt_en_s     = digit_en;
         nxt_dp_s     = dp_in;
      end else begin
         nxt_digits_s = shadow_digits_r;
         nxt_en_s     = shadow_en_r;
         nxt_dp_s     = shadow_dp_r;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it reads 0 and every higher digit is dark or zero.
   always_comb begin : lz_blk
      logic run_v;
      lz_blank_s = 8'h00;
      run_v      = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         lz_blank_s[i] = run_v & nxt_en_s[i] & (nxt_digits_s[i*4 +: 4] == 4'h0);
         run_v         = run_v & (~nxt_en_s[i] | (nxt_digits_s[i*4 +: 4] == 4'h0));
      end
   end
`else
   // Zeros are always displayed as 0.
   always_comb begin
      lz_blank_s = 8'h00;
   end
`endif

   // Decode the digit that becomes selected at the next tick.
   always_comb begin
      sel_nib_s = nxt_digits_s[{nxt_idx_s, 2'b00} +: 4];
      if (nxt_en_s[nxt_idx_s] && !lz_blank_s[nxt_idx_s]) begin
         anode_nxt_s = ~(8'h01 << nxt_idx_s);
         bcd_nxt_s   = sel_nib_s;
         dp_n_nxt_s  = ~nxt_dp_s[nxt_idx_s];
      end else begin
         anode_nxt_s = 8'hFF;
         bcd_nxt_s   = 4'hF;
         dp_n_nxt_s  = 1'b1;
      end
   end

   // Prescaler and digit index; index starts at 7 so the first tick is a frame boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_r <= '0;
         idx_r   <= 3'd7;
      end else if (tick_s) begin
         presc_r <= '0;
         idx_r   <= nxt_idx_s;
      end else begin
         presc_r <= presc_r + CW'(1);
         idx_r   <= idx_r;
      end
   end

   // Shadow registers, captured only at a frame boundary with load requested.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_digits_r <= 32'hFFFF_FFFF;
         shadow_en_r     <= 8'h00;
         shadow_dp_r     <= 8'h00;
      end else if (capture_s) begin
         shadow_digits_r <= digits_in;
         shadow_en_r     <= digit_en;
         shadow_dp_r     <= dp_in;
      end else begin
         shadow_digits_r <= shadow_digits_r;
         shadow_en_r     <= shadow_en_r;
         shadow_dp_r     <= shadow_dp_r;
      end
   end

   // Registered display outputs, refreshed on each tick for the new index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         anode_r       <= 8'hFF;
         bcd_r         <= 4'hF;
         dp_n_r        <= 1'b1;
         frame_start_r <= 1'b0;
      end else if (tick_s) begin
         anode_r       <= anode_nxt_s;
         bcd_r         <= bcd_nxt_s;
         dp_n_r        <= dp_n_nxt_s;
         frame_start_r <= boundary_s;
      end else begin
         anode_r       <= anode_r;
         bcd_r         <= bcd_r;
         dp_n_r        <= dp_n_r;
         frame_start_r <= 1'b0;
      end
   end

   // load_ack marks the capture cycle itself, so it follows the held load level.
   assign load_ack    = capture_s;
   assign anode       = anode_r;
   assign BCD         = bcd_r;
   assign dp_n        = dp_n_r;
   assign frame_start = frame_start_r;

endmodule
